// File: rtl/logic_reduce_accum_pkg.sv
// Shared op codes, FSM state encodings and op helpers for the logic reduce/accumulate block.
package logic_reduce_accum_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    // NAND folds as AND; the inversion is applied once to the final result.
    function automatic op_t op_core(input op_t op);
        return (op == OP_NAND) ? OP_AND : op;
    endfunction

endpackage

// File: rtl/logic_reduce_accum_lane_reduce.sv
// Purely combinational NUM_IN-lane bitwise fold; NAND is folded as AND.
module lane_reduce
    import logic_reduce_accum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [1:0]              op,
    input  logic [NUM_IN*WIDTH-1:0] data,
    output logic [WIDTH-1:0]        result
);

    function automatic logic [WIDTH-1:0] fold2(input op_t o, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (o)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        result = data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            result = fold2(op_core(op_t'(op)), result, data[k*WIDTH +: WIDTH]);
        end
    end

endmodule

// File: rtl/logic_reduce_accum.sv
// Handshaked multi-lane bitwise reducer that accumulates the beats of a packet into one result.
module logic_reduce_accum
    import logic_reduce_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [1:0]                         op_sel,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_IN*WIDTH-1:0]            in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(MAX_BEATS+1)-1:0]     out_beats,
    output logic                               out_overflow
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_eff;
    logic [WIDTH-1:0] acc_q, acc_d, lane_r, acc_fold;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, first_beat, close_beat;

    // The op is taken from op_sel only on the first beat; later beats reuse the latched copy.
    assign first_beat = (state_q == ST_IDLE);
    assign op_eff     = first_beat ? op_sel : op_q;

    lane_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_lane_reduce (
        .op     (op_eff),
        .data   (in_data),
        .result (lane_r)
    );

    lane_reduce #(.WIDTH(WIDTH), .NUM_IN(2)) u_acc_fold (
        .op     (op_eff),
        .data   ({lane_r, acc_q}),
        .result (acc_fold)
    );

    always_comb begin
        accept     = in_valid && in_ready;
        cnt_d      = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
        acc_d      = first_beat ? lane_r : acc_fold;
        close_beat = in_last || (cnt_d == CNT_W'(MAX_BEATS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_d = close_beat ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q != ST_HOLD);
        out_valid = (state_q == ST_HOLD);
    end

    // Only accepted beats touch acc, so X on in_data while idle never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            op_q         <= OP_AND;
            cnt_q        <= '0;
            out_data     <= '0;
            out_beats    <= '0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (first_beat) begin
                op_q <= op_eff;
            end
            if (close_beat) begin
                out_data     <= (op_eff == OP_NAND) ? ~acc_d : acc_d;
                out_beats    <= cnt_d;
                out_overflow <= !in_last;
            end
        end
    end

endmodule

// File: tb/tb_logic_reduce_accum.sv
// Scoreboard bench: driver feeds a packet-level reference model, a monitor pops and compares outputs.
module tb_logic_reduce_accum;

    localparam int WIDTH     = 8;
    localparam int NUM_IN    = 4;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [1:0]               op_sel = 2'b00;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [NUM_IN*WIDTH-1:0]  in_data = '0;
    logic                     in_last = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [WIDTH-1:0]         out_data;
    logic [CNT_W-1:0]         out_beats;
    logic                     out_overflow;

    logic       s_op_sel = 2'b00;
    logic [1:0] s_op = 2'b00;
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [1:0] s_in_data = '0;
    logic       s_in_last = 1'b0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [0:0] s_out_data;
    logic [2:0] s_out_beats;
    logic       s_out_overflow;

    always #5 clk = ~clk;

    logic_reduce_accum #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_beats(out_beats), .out_overflow(out_overflow)
    );

    logic_reduce_accum #(.WIDTH(1), .NUM_IN(2), .MAX_BEATS(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .op_sel(s_op), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_beats(s_out_beats), .out_overflow(s_out_overflow)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] beats;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a packet's result is the op applied across every lane of every beat.
    logic [WIDTH-1:0] cur_lanes[$];
    int               cur_n = 0;
    logic [1:0]       cur_op = 2'b00;

    function automatic void model_beat(input logic [1:0] op, input logic [NUM_IN*WIDTH-1:0] d,
                                       input logic last);
        logic [WIDTH-1:0] r;
        if (cur_n == 0) cur_op = op;
        for (int k = 0; k < NUM_IN; k++) cur_lanes.push_back(d[k*WIDTH +: WIDTH]);
        cur_n++;
        if (last || cur_n == MAX_BEATS) begin
            r = cur_lanes[0];
            for (int i = 1; i < cur_lanes.size(); i++) begin
                case (cur_op)
                    2'b01:   r = r | cur_lanes[i];
                    2'b10:   r = r ^ cur_lanes[i];
                    default: r = r & cur_lanes[i];
                endcase
            end
            if (cur_op == 2'b11) r = ~r;
            exp_q.push_back('{data: r, beats: CNT_W'(cur_n), ovf: !last});
            cur_lanes.delete();
            cur_n = 0;
        end
    endfunction

    function automatic void model_reset();
        cur_lanes.delete();
        cur_n = 0;
    endfunction

    task automatic send_beat(input logic [1:0] op, input logic [NUM_IN*WIDTH-1:0] d,
                             input logic last);
        int  w;
        logic closes;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        op_sel   = op;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1 at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        closes = last || (cur_n + 1 == MAX_BEATS);
        @(posedge clk);
        model_beat(op, d, last);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
        if (closes) begin
            @(negedge clk);
            check("result_latency", out_valid, 1'b1);
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    logic force_rdy = 1'b0;
    logic rdy_val = 1'b1;

    always begin
        @(posedge clk);
        #1;
        out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    logic             have_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [CNT_W-1:0] prev_beats;
    logic             prev_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            check("in_ready_vs_hold", in_ready, !out_valid);
            if (out_valid) begin
                if (have_prev) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_beats_stable", out_beats, prev_beats);
                    check("stall_ovf_stable", out_overflow, prev_ovf);
                end
                if (out_ready) begin
                    have_prev = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0h required=none", out_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_beats", out_beats, e.beats);
                        check("out_overflow", out_overflow, e.ovf);
                    end
                end else begin
                    have_prev  = 1'b1;
                    prev_data  = out_data;
                    prev_beats = out_beats;
                    prev_ovf   = out_overflow;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic a, b, e;
        logic [1:0] v;

        // Reset held with a valid beat offered
        in_valid = 1'b1;
        in_data  = $urandom;
        in_last  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_beats", out_beats, 0);
        check("rst_out_overflow", out_overflow, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_data  = 'x;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 1'b1);

        // All 1-bit lane combinations for every op on the WIDTH=1, NUM_IN=2 instance
        for (int op = 0; op < 4; op++) begin
            for (int vi = 0; vi < 4; vi++) begin
                v = 2'(vi);
                a = v[0];
                b = v[1];
                case (op)
                    1:       e = a | b;
                    2:       e = a ^ b;
                    3:       e = ~(a & b);
                    default: e = a & b;
                endcase
                @(negedge clk);
                s_op = 2'(op);
                s_in_data = v;
                s_in_valid = 1'b1;
                s_in_last = 1'b1;
                w = 0;
                while (!s_in_ready && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                @(posedge clk);
                #1;
                s_in_valid = 1'b0;
                @(negedge clk);
                check($sformatf("sweep_valid_op%0d_v%0d", op, vi), s_out_valid, 1'b1);
                check($sformatf("sweep_data_op%0d_v%0d", op, vi), s_out_data, e);
            end
        end

        // AND single beat, XOR two beats, NAND pair
        send_beat(2'b00, 32'h3FF30FFF, 1'b1);
        send_beat(2'b10, 32'h08040201, 1'b0);
        send_beat(2'b01, 32'h000000F0, 1'b1);
        send_beat(2'b11, 32'hFFFFFFFF, 1'b1);
        send_beat(2'b11, 32'h7FFFFFFF, 1'b1);
        wait_drain();

        // Backpressure: result held for 5 cycles
        force_rdy = 1'b1;
        rdy_val   = 1'b0;
        @(posedge clk);
        send_beat(2'b01, 32'h11224488, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid_held", out_valid, 1'b1);
            check("bp_in_ready_low", in_ready, 1'b0);
        end
        rdy_val = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        force_rdy = 1'b0;
        wait_drain();

        // Overflow: four beats close by count, fifth beat opens a new packet
        send_beat(2'b01, 32'h00000001, 1'b0);
        send_beat(2'b01, 32'h00000002, 1'b0);
        send_beat(2'b01, 32'h00000004, 1'b0);
        send_beat(2'b01, 32'h00000008, 1'b0);
        send_beat(2'b01, 32'h00000010, 1'b0);
        send_beat(2'b01, 32'h00000020, 1'b1);
        // Last beat arriving exactly at the count limit closes normally
        send_beat(2'b10, $urandom, 1'b0);
        send_beat(2'b10, $urandom, 1'b0);
        send_beat(2'b10, $urandom, 1'b0);
        send_beat(2'b10, $urandom, 1'b1);
        wait_drain();

        // Reset mid-packet drops the partial packet
        send_beat(2'b01, 32'h0000000F, 1'b0);
        send_beat(2'b01, 32'h000000F0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_output", out_valid, 1'b0);
        end
        send_beat(2'b00, 32'hF0F0F0F0, 1'b1);
        wait_drain();

        // Randomized packet stream with idle gaps, mid-packet op changes and X on idle data
        for (int p = 0; p < 60; p++) begin
            int len;
            logic [1:0] pop;
            len = $urandom_range(1, 6);
            pop = 2'($urandom_range(0, 3));
            for (int bt = 0; bt < len; bt++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat((bt == 0) ? pop : 2'($urandom_range(0, 3)), $urandom, bt == len - 1);
            end
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
